// File: rtl/bcd_pkg.sv
// Shared BCD conversion types, constants and width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Width of the binary value that holds any DIGITS-digit decimal number.
  function automatic int unsigned bin_width(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready handshake bundle between a BCD source and the converter.
interface bcd2bin_seq_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned BIN_W = bcd_pkg::bin_width(DIGITS);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      binary;
  logic                  err;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, binary, err
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, binary, err
  );
endinterface

// File: rtl/bcd_digit_mac.sv
// Combinational acc*10 + digit step with an invalid-digit flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_next,
  output logic             digit_bad
);

  // Multiply by ten as shift-and-add; result truncated to BIN_W.
  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + BIN_W'(digit);
    digit_bad = (digit > BCD_DIGIT_MAX);
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_seq_if.slave  bus
);

  localparam int unsigned BIN_W = bin_width(DIGITS);
  localparam int unsigned SR_W  = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t            state, state_nx;
  logic [SR_W-1:0]   sreg;
  logic [BIN_W-1:0]  acc;
  logic [BIN_W-1:0]  acc_nx;
  logic [CNT_W-1:0]  cnt;
  logic              err_int;
  logic              digit_bad;
  logic              err_sum;
  logic [BIN_W-1:0]  binary_q;
  logic              err_q;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc       (acc),
    .digit     (sreg[SR_W-1 -: 4]),
    .acc_next  (acc_nx),
    .digit_bad (digit_bad)
  );

  assign err_sum = err_int | digit_bad;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = CONV;
      end
      CONV: begin
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, digit-serial accumulate, result registers.
  // Result is loaded on the last CONV cycle so it is valid on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_int  <= 1'b0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg    <= bus.bcd;
            acc     <= '0;
            cnt     <= '0;
            err_int <= 1'b0;
          end
        end
        CONV: begin
          sreg    <= sreg << 4;
          acc     <= acc_nx;
          err_int <= err_sum;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            binary_q <= err_sum ? '0 : acc_nx;
            err_q    <= err_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.binary = binary_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: 4-digit and 1-digit instances.
module tb_bcd2bin_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bcd2bin_seq_if #(.DIGITS(4)) a ();
  bcd2bin_seq_if #(.DIGITS(1)) b ();

  bcd2bin_seq #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(a));
  bcd2bin_seq #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic xfer4(input logic [15:0] w, input logic [13:0] eb, input logic ee,
                       input bit keep_valid);
    int n;
    a.in_valid = 1'b1;
    a.bcd      = w;
    n = 0;
    while (!a.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait4", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) a.in_valid = 1'b0;
    n = 0;
    while (!a.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("latency4", 32'(n), 32'd4);
    chk("binary4", 32'(a.binary), 32'(eb));
    chk("err4", 32'(a.err), 32'(ee));
    chk("in_ready_done4", 32'(a.in_ready), 32'd0);
    @(negedge clk);
    chk("out_valid_drop4", 32'(a.out_valid), 32'd0);
    chk("in_ready_back4", 32'(a.in_ready), 32'd1);
  endtask

  task automatic xfer1(input logic [3:0] w, input logic [3:0] eb, input logic ee);
    int n;
    b.in_valid = 1'b1;
    b.bcd      = w;
    n = 0;
    while (!b.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait1", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b.in_valid = 1'b0;
    n = 0;
    while (!b.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("latency1", 32'(n), 32'd1);
    chk("binary1", 32'(b.binary), 32'(eb));
    chk("err1", 32'(b.err), 32'(ee));
    @(negedge clk);
    chk("in_ready_back1", 32'(b.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    tbl[0] = '{bcd: 16'h0000, bin: 14'd0,    err: 1'b0};
    tbl[1] = '{bcd: 16'h1234, bin: 14'd1234, err: 1'b0};
    tbl[2] = '{bcd: 16'h9999, bin: 14'd9999, err: 1'b0};
    tbl[3] = '{bcd: 16'h12A4, bin: 14'd0,    err: 1'b1};
    tbl[4] = '{bcd: 16'h0042, bin: 14'd42,   err: 1'b0};
    tbl[5] = '{bcd: 16'h5000, bin: 14'd5000, err: 1'b0};
    tbl[6] = '{bcd: 16'hF001, bin: 14'd0,    err: 1'b1};
    tbl[7] = '{bcd: 16'h0001, bin: 14'd1,    err: 1'b0};

    rst         = 1'b1;
    a.in_valid  = 1'b0;
    a.bcd       = '0;
    a.out_ready = 1'b1;
    b.in_valid  = 1'b0;
    b.bcd       = '0;
    b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(a.in_ready), 32'd1);
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_binary", 32'(a.binary), 32'd0);
    chk("rst_err", 32'(a.err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word with in_valid pulsed.
    xfer4(16'h0000, 14'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Table, in_valid held high across back-to-back words.
    for (int i = 0; i < 8; i++) begin
      xfer4(tbl[i].bcd, tbl[i].bin, tbl[i].err, 1'b1);
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_table", 32'(a.in_ready), 32'd1);

    // Backpressure: out_ready low for 10 cycles after out_valid.
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.bcd       = 16'h0507;
    @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0;
    n = 0;
    while (!a.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(a.out_valid), 32'd1);
      chk("bp_binary", 32'(a.binary), 32'd507);
      chk("bp_in_ready", 32'(a.in_ready), 32'd0);
      @(negedge clk);
    end
    a.out_ready = 1'b1;
    chk("bp_still_valid", 32'(a.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_released_valid", 32'(a.out_valid), 32'd0);
    chk("bp_released_ready", 32'(a.in_ready), 32'd1);

    // Reset during CONV discards the word and clears held result.
    a.in_valid = 1'b1;
    a.bcd      = 16'h8765;
    @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("mid_rst_binary", 32'(a.binary), 32'd0);
    chk("mid_rst_err", 32'(a.err), 32'd0);
    chk("mid_rst_in_ready", 32'(a.in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_output", 32'(a.out_valid), 32'd0);
    xfer4(16'h0001, 14'd1, 1'b0, 1'b0);

    // Single-digit instance.
    xfer1(4'h9, 4'd9, 1'b0);
    xfer1(4'hF, 4'd0, 1'b1);
    xfer1(4'h3, 4'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential converter from packed multi-digit BCD to unsigned binary; the inverse of the team's bin2bcd converter.
- Processes one BCD digit per clock, most-significant digit first: acc = acc*10 + digit.
- Valid/ready handshake on both input and output, so it sits between a BCD source (keypad/display path) and binary datapath logic.
- Flags any nibble greater than 9 as an error.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd input (>=1).
- BIN_W, derived localparam = $clog2(10**DIGITS), binary output width (14 for DIGITS=4). Not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  bcd holds a word to convert.
- in_ready  output  1  converter can accept a word.
- bcd  input  4*DIGITS  packed BCD; digit i occupies bits [4i+3:4i]; digit DIGITS-1 is most significant.
- out_valid  output  1  binary/err hold a completed result.
- out_ready  input  1  consumer accepts the result.
- binary  output  BIN_W  converted value.
- err  output  1  at least one input nibble was greater than 9.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, in_ready=1, out_valid=0, binary=0, err=0; internal accumulator, digit shift register and counter cleared. Reset overrides every other event, including mid-conversion; any in-flight word is discarded.
- States: IDLE, CONV, DONE (enum in package).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch bcd into a shift register, acc=0, cnt=0, err_int=0, go to CONV.
  - bcd is not sampled again after this capture.
- CONV:
  - in_ready=0, out_valid=0.
  - Each cycle: d = top nibble of the shift register; acc <= acc*10 + d (computed as (acc<<3)+(acc<<1)+d, truncated to BIN_W); shift register shifts left 4; err_int |= (d>9); cnt++.
  - After DIGITS cycles (cnt==DIGITS-1 processed), go to DONE.
- Output registers on entry to DONE:
  - binary = err_int ? 0 : acc_final.
  - err = err_int.
  - out_valid = 1.
- DONE:
  - binary and err held stable while out_valid=1 && out_ready=0 (backpressure of any length).
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_ready=0 in DONE; no bypass, so the next word is accepted at the earliest one cycle after the result handshake.
- Latency: input accepted at edge N, out_valid=1 visible after edge N+DIGITS.
- Throughput: at most one word per DIGITS+2 cycles.
- Handshake signals are level-based. in_valid held through an accepted transfer starts no second conversion until IDLE is re-entered.
- Arithmetic:
  - For valid BCD the result is always below 10**DIGITS, so it fits BIN_W and truncation never occurs.
  - With invalid digits the intermediate may overflow. This is harmless because the output is forced to 0.
- Corners:
  - All-zero input gives 0.
  - All nines gives 10**DIGITS-1.
  - DIGITS=1 passes the nibble through when it is 9 or less (1-cycle CONV).
- binary and err are undefined-free (driven to the reset/held value) whenever out_valid=0; consumers ignore them then.

Decomposition:
- Package bcd_pkg:
  - state enum typedef (IDLE, CONV, DONE).
  - localparam BCD_DIGIT_MAX=9.
  - function bin_width(digits) returning $clog2(10**digits), shared with bin2bcd wrappers.
- Sub-module bcd_digit_mac:
  - Combinational acc*10+digit with digit-invalid flag, parameterised on BIN_W.
  - Reusable by a future parallel converter.
- The FSM, counter and registers live in bcd2bin_seq.

Test Plan:
- DIGITS=4, reset, bcd=16'h0000, in_valid one cycle, out_ready=1 -> out_valid rises 4 cycles after accept, binary=0, err=0, in_ready back to 1 one cycle after handshake.
- bcd=16'h1234 -> binary=1234 (0x04D2), err=0; bcd=16'h9999 -> binary=9999 (0x270F), err=0; back-to-back words with in_valid held high are each converted exactly once.
- bcd=16'h12A4 -> err=1, binary=0; a following bcd=16'h0042 -> err=0, binary=42 (err does not stick across transactions).
- bcd=16'h0507 with out_ready=0 for 10 cycles after out_valid -> binary=507 and out_valid stable throughout, in_ready=0; release out_ready -> IDLE next cycle.
- Accept bcd=16'h8765, assert rst at cycle 2 of CONV -> next cycle out_valid=0, binary=0, err=0, in_ready=1; a new word 16'h0001 then yields binary=1.
- DIGITS=1 instance: bcd=4'h9 -> binary=9 after 1 cycle; bcd=4'hF -> err=1, binary=0.
